// File: rtl/sprite_pkg.sv
// Shared types and defaults for the per-fighter sprite pixel pipeline.
// Holds the RGB struct, palette depth, colour key and per-fighter frame counts.
package sprite_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int          CODE_W_DEF  = 4;
  localparam int          PAL_DEPTH   = 2**CODE_W_DEF;
  localparam logic [23:0] KEY_RGB_DEF = 24'hFFFFFF;

  localparam int FRAMES_FIGHTER_A = 32;
  localparam int FRAMES_FIGHTER_B = 24;
  localparam int FRAMES_FIGHTER_C = 28;

endpackage

// File: rtl/sprite_palette_ram.sv
// Palette register file: one synchronous write port, one registered read port.
// Read latency 1 cycle, old data returned on same-index collision; no backpressure.
module sprite_palette_ram
  import sprite_pkg::*;
#(
  parameter int CODE_W = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              we,
  input  logic [CODE_W-1:0] wr_idx,
  input  rgb_t              wr_data,
  input  logic              rd_en,
  input  logic [CODE_W-1:0] rd_idx,
  output rgb_t              rd_data
);

  localparam int DEPTH = 2**CODE_W;

  rgb_t mem_q [DEPTH];
  rgb_t mem_d [DEPTH];
  rgb_t rd_q;
  rgb_t rd_d;

  // Read samples mem_q, so a write in the same cycle is only seen next cycle.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_idx] = wr_data;
    end
    rd_d = rd_q;
    if (rd_en) begin
      rd_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/sprite_pixel_pipe.sv
// Sprite pixel pipe: (x,y)+frame -> ROM address -> palette RGB with transparency/OOB keying.
// Latency pix_valid N -> out_valid N+3, 1 pixel/cycle; no backpressure, bubbles hold outputs.
module sprite_pixel_pipe
  import sprite_pkg::*;
#(
  parameter int          NUM_FRAMES  = 32,
  parameter int          FRAME_W     = 6,
  parameter int          SPRITE_W    = 128,
  parameter int          SPRITE_H    = 128,
  parameter int          ADDR_W      = 19,
  parameter int          CODE_W      = 4,
  parameter int          TRANSP_CODE = 0,
  parameter logic [23:0] KEY_RGB     = KEY_RGB_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic [FRAME_W-1:0] frame_sel,
  input  logic               flip,
  input  logic               pix_valid,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  output logic [FRAME_W-1:0] rom_frame,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [CODE_W-1:0]  rom_code,
  input  logic               pal_we,
  input  logic [CODE_W-1:0]  pal_idx,
  input  logic [23:0]        pal_data,
  output logic               out_valid,
  output logic [7:0]         Red,
  output logic [7:0]         Green,
  output logic [7:0]         Blue,
  output logic               zero
);

  logic [FRAME_W-1:0] frame_q, frame_d, frame_eff, frame_ok;
  logic               flip_q, flip_d, flip_eff;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d, addr_lin;
  logic [FRAME_W-1:0] rom_frame_q, rom_frame_d;
  logic               v0_q, v0_d, oob0_q, oob0_d;
  logic               v1_q, v1_d, oob1_q, oob1_d;
  logic               out_valid_q, out_valid_d;
  logic               zero_q, zero_d;
  logic               oob;
  logic [9:0]         xm;
  rgb_t               pal_rd;

  always_comb begin
    frame_ok  = (32'(frame_sel) < 32'(NUM_FRAMES)) ? frame_sel : '0;
    // The same select feeds the latch and this cycle's address, so a
    // pixel coinciding with frame_start already uses the new frame/flip.
    frame_eff = frame_start ? frame_ok : frame_q;
    flip_eff  = frame_start ? flip : flip_q;
    frame_d   = frame_eff;
    flip_d    = flip_eff;

    oob      = (32'(pix_x) >= 32'(SPRITE_W)) || (32'(pix_y) >= 32'(SPRITE_H));
    xm       = flip_eff ? (10'(SPRITE_W - 1) - pix_x) : pix_x;
    addr_lin = ADDR_W'(pix_y) * ADDR_W'(SPRITE_W) + ADDR_W'(xm);

    v0_d        = pix_valid;
    rom_addr_d  = rom_addr_q;
    rom_frame_d = rom_frame_q;
    oob0_d      = oob0_q;
    if (pix_valid) begin
      // A mirrored out-of-range x wraps in xm; forcing 0 keeps it off the ROM.
      rom_addr_d  = oob ? '0 : addr_lin;
      rom_frame_d = frame_eff;
      oob0_d      = oob;
    end

    v1_d   = v0_q;
    oob1_d = oob0_q;

    out_valid_d = v1_q;
    zero_d      = zero_q;
    if (v1_q) begin
      zero_d = oob1_q || (rom_code == CODE_W'(TRANSP_CODE));
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_q     <= '0;
      flip_q      <= 1'b0;
      rom_addr_q  <= '0;
      rom_frame_q <= '0;
      v0_q        <= 1'b0;
      oob0_q      <= 1'b0;
      v1_q        <= 1'b0;
      oob1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      frame_q     <= frame_d;
      flip_q      <= flip_d;
      rom_addr_q  <= rom_addr_d;
      rom_frame_q <= rom_frame_d;
      v0_q        <= v0_d;
      oob0_q      <= oob0_d;
      v1_q        <= v1_d;
      oob1_q      <= oob1_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
    end
  end

  // The palette's registered read is the stage-2 colour register.
  sprite_palette_ram #(
    .CODE_W (CODE_W)
  ) u_palette (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .we      (pal_we),
    .wr_idx  (pal_idx),
    .wr_data (rgb_t'(pal_data)),
    .rd_en   (v1_q),
    .rd_idx  (rom_code),
    .rd_data (pal_rd)
  );

  assign rom_addr  = rom_addr_q;
  assign rom_frame = rom_frame_q;
  assign out_valid = out_valid_q;
  assign zero      = zero_q;
  assign {Red, Green, Blue} = zero_q ? KEY_RGB : pal_rd;

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Bench for sprite_pixel_pipe: directed plan items plus random traffic against a reference model.
module tb_sprite_pixel_pipe;

  localparam int SW  = 128;
  localparam int SH  = 128;
  localparam int NF  = 32;
  localparam logic [23:0] KEY = 24'hFFFFFF;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [5:0]  frame_sel = '0;
  logic        flip = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic [5:0]  rom_frame;
  logic [18:0] rom_addr;
  logic [3:0]  rom_code = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = '0;
  logic [23:0] pal_data = '0;
  logic        out_valid;
  logic [7:0]  Red, Green, Blue;
  logic        zero;

  int checks = 0;
  int failures = 0;

  sprite_pixel_pipe dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .frame_sel(frame_sel),
    .flip(flip), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .rom_frame(rom_frame), .rom_addr(rom_addr), .rom_code(rom_code),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .out_valid(out_valid), .Red(Red), .Green(Green), .Blue(Blue), .zero(zero)
  );

  always #5 Clk = ~Clk;

  // ROM contents: fixed codes at the plan addresses, a hash elsewhere.
  function automatic logic [3:0] rom_fn(input int frame, input int addr);
    if (frame == 0 && addr == 261) return 4'd3;
    if (frame == 0 && addr == 378) return 4'd0;
    return 4'((addr * 5) ^ (addr >> 4) ^ (frame * 3));
  endfunction

  always @(posedge Clk) rom_code <= rom_fn(int'(rom_frame), int'(rom_addr));

  // Reference state.
  logic [23:0] m_pal [16];
  int          m_frame, m_flip;
  bit          h_v [2];
  int          h_addr [2], h_frame [2];
  bit          h_oob [2];
  bit          exp_v;
  logic [23:0] cur_rgb;
  bit          cur_zero;
  int          stream_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pal[i] = '0;
    m_frame = 0; m_flip = 0;
    for (int i = 0; i < 2; i++) begin
      h_v[i] = 0; h_addr[i] = 0; h_frame[i] = 0; h_oob[i] = 0;
    end
    exp_v = 0; cur_rgb = '0; cur_zero = 0;
  endtask

  // One cycle: check what the last edge produced, drive this cycle, advance the model.
  task automatic step(input bit pv, input int x, input int y, input bit fs, input int fsel,
                      input bit fl, input bit we, input int widx, input logic [23:0] wdat);
    bit  oob;
    int  xm, addr, code;
    @(negedge Clk);
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
    check("zero", {31'b0, zero}, {31'b0, cur_zero});
    check("rgb", {8'b0, Red, Green, Blue}, {8'b0, cur_rgb});
    if (h_v[0]) begin
      check("rom_addr", {13'b0, rom_addr}, h_addr[0]);
      check("rom_frame", {26'b0, rom_frame}, h_frame[0]);
    end
    if (out_valid) stream_cnt++;

    pix_valid = pv; pix_x = 10'(x); pix_y = 10'(y);
    frame_start = fs; frame_sel = 6'(fsel); flip = fl;
    pal_we = we; pal_idx = 4'(widx); pal_data = wdat;

    if (fs) begin
      m_frame = (fsel >= NF) ? 0 : fsel;
      m_flip  = fl;
    end
    oob  = (x >= SW) || (y >= SH);
    xm   = m_flip ? (SW - 1 - x) : x;
    addr = oob ? 0 : (y * SW + xm);

    // Colour lookup for the pixel requested two cycles ago, before this cycle's write.
    exp_v = h_v[1];
    if (h_v[1]) begin
      code     = int'(rom_fn(h_frame[1], h_addr[1]));
      cur_zero = h_oob[1] || (code == 0);
      cur_rgb  = cur_zero ? KEY : m_pal[code];
    end
    if (we) m_pal[widx] = wdat;

    h_v[1] = h_v[0]; h_addr[1] = h_addr[0]; h_frame[1] = h_frame[0]; h_oob[1] = h_oob[0];
    h_v[0] = pv; h_addr[0] = addr; h_frame[0] = m_frame; h_oob[0] = oob;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 24'h0);
  endtask

  task automatic pix(input int x, input int y);
    step(1, x, y, 0, 0, 0, 0, 0, 24'h0);
  endtask

  initial begin
    model_reset();
    stream_cnt = 0;
    repeat (3) @(negedge Clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_rgb", {8'b0, Red, Green, Blue}, 32'd0);
    check("rst_rom_addr", {13'b0, rom_addr}, 32'd0);
    check("rst_rom_frame", {26'b0, rom_frame}, 32'd0);
    Reset_n = 1'b1;

    // Palette load and a plain pixel.
    step(0, 0, 0, 0, 0, 0, 1, 3, 24'h3952CE);
    pix(5, 2);
    idle();
    check("plain_addr", {13'b0, rom_addr}, 32'd261);
    idle(); idle();
    check("plain_rgb", {8'b0, Red, Green, Blue}, 32'h003952CE);
    check("plain_zero", {31'b0, zero}, 32'd0);

    // Mirrored pixel lands on a transparent code.
    step(1, 5, 2, 1, 0, 1, 0, 0, 24'h0);
    idle();
    check("flip_addr", {13'b0, rom_addr}, 32'd378);
    idle(); idle();
    check("transp_zero", {31'b0, zero}, 32'd1);
    check("transp_rgb", {8'b0, Red, Green, Blue}, 32'h00FFFFFF);

    // Out-of-bounds x, mirrored and not.
    pix(128, 2);
    idle();
    check("oob_addr", {13'b0, rom_addr}, 32'd0);
    idle(); idle();
    check("oob_zero", {31'b0, zero}, 32'd1);
    step(1, 128, 2, 1, 0, 0, 0, 0, 24'h0);
    step(1, 7, 200, 0, 0, 0, 0, 0, 24'h0);
    idle(); idle(); idle();

    // Frame latching only on frame_start.
    step(1, 1, 1, 1, 7, 0, 0, 0, 24'h0);
    step(1, 1, 1, 0, 9, 0, 0, 0, 24'h0);
    idle();
    check("frame_hold", {26'b0, rom_frame}, 32'd7);
    step(1, 1, 1, 1, 9, 0, 0, 0, 24'h0);
    idle();
    check("frame_new", {26'b0, rom_frame}, 32'd9);
    step(1, 1, 1, 1, 40, 0, 0, 0, 24'h0);
    idle();
    check("frame_clamp", {26'b0, rom_frame}, 32'd0);
    idle(); idle();

    // Palette write colliding with a stage-2 lookup of the same index.
    step(1, 5, 2, 1, 0, 0, 0, 0, 24'h0);
    pix(5, 2);
    step(0, 0, 0, 0, 0, 0, 1, 3, 24'h123456);
    idle();
    check("coll_old", {8'b0, Red, Green, Blue}, 32'h003952CE);
    idle();
    check("coll_new", {8'b0, Red, Green, Blue}, 32'h00123456);
    idle(); idle();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 140), $urandom_range(0, 140),
           $urandom_range(0, 15) == 0, $urandom_range(0, 47), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 15), 24'($urandom));
    end
    idle(); idle(); idle();

    // 20 back-to-back pixels.
    stream_cnt = 0;
    for (int i = 0; i < 20; i++) pix($urandom_range(0, 127), $urandom_range(0, 127));
    repeat (5) idle();
    check("stream_cnt", stream_cnt, 32'd20);

    // Reset in the middle of a burst.
    for (int i = 0; i < 10; i++) pix($urandom_range(0, 127), $urandom_range(0, 127));
    #2 Reset_n = 1'b0;
    #1 check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    pix_valid = 1'b0;
    model_reset();
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    stream_cnt = 0;
    repeat (6) idle();
    check("rst_no_stale", stream_cnt, 32'd0);
    for (int i = 0; i < 8; i++) pix($urandom_range(0, 130), $urandom_range(0, 130));
    repeat (4) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_pipe.md
Name: sprite_pixel_pipe

Overview:
- Parametrised per-fighter pixel pipeline: maps an in-sprite (x,y) coordinate and a selected animation frame to 24-bit RGB plus a transparency flag.
- Sits between the VGA sprite placement logic and the compositor.
- Over the fixed per-character mapper it adds:
  - a runtime-writable palette;
  - tear-free frame/flip latching at frame start;
  - horizontal mirroring;
  - out-of-bounds masking;
  - a valid-qualified, fixed-latency pipeline.
- Sprite ROMs sit outside the block behind a 1-cycle read port.

Parameters:
- NUM_FRAMES, 32, number of animation frames in the external ROM bank
- FRAME_W, 6, width of frame_sel/rom_frame
- SPRITE_W, 128, sprite width in pixels
- SPRITE_H, 128, sprite height in pixels
- ADDR_W, 19, ROM pixel address width; must be >= clog2(SPRITE_W*SPRITE_H)
- CODE_W, 4, colour-code width; palette depth = 2**CODE_W
- TRANSP_CODE, 0, code treated as transparent
- KEY_RGB, 24'hFFFFFF, RGB driven when a pixel is transparent

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of a video frame
- frame_sel  in  FRAME_W  requested animation frame
- flip  in  1  requested horizontal mirror (fighter facing left)
- pix_valid  in  1  pixel request valid this cycle
- pix_x  in  10  signed-free x offset within sprite box
- pix_y  in  10  y offset within sprite box
- rom_frame  out  FRAME_W  frame index to ROM bank
- rom_addr  out  ADDR_W  pixel address to ROM bank
- rom_code  in  CODE_W  ROM data, valid one cycle after rom_addr
- pal_we  in  1  palette write strobe
- pal_idx  in  CODE_W  palette entry to write
- pal_data  in  24  RGB 8:8:8 to write
- out_valid  out  1  output pixel valid
- Red, Green, Blue  out  8 each  pixel colour
- zero  out  1  pixel transparent

Behaviour:
- Reset (async assert, sync release):
  - every palette entry = 24'h000000;
  - latched frame = 0, latched flip = 0;
  - out_valid = 0, zero = 0, Red/Green/Blue = 0;
  - rom_addr = 0, rom_frame = 0;
  - all pipeline valid bits cleared.
- Latching:
  - frame_sel and flip are captured only on a cycle with frame_start=1.
  - Between pulses, changes on frame_sel/flip have no effect.
  - frame_sel >= NUM_FRAMES latches as 0.
- Stage 0 (cycle of pix_valid), registered:
  - xm = flip ? SPRITE_W-1-pix_x : pix_x;
  - rom_addr = pix_y*SPRITE_W + xm, truncated to ADDR_W;
  - rom_frame = latched frame;
  - oob flag = (pix_x >= SPRITE_W) || (pix_y >= SPRITE_H).
  - When oob=1, rom_addr = 0 and the xm arithmetic must not underflow into a valid address.
- Stage 1 (ROM returns rom_code): code, oob and valid are carried forward.
- Stage 2 (registered outputs, exactly 2 cycles after the rom_addr register):
  - If oob or code == TRANSP_CODE: zero = 1, RGB = KEY_RGB.
  - Otherwise: zero = 0, RGB = palette[code].
- Latency: pix_valid at cycle N gives out_valid at cycle N+3, fully pipelined at 1 pixel/cycle.
- No backpressure. Bubbles propagate: out_valid=0 holds the previous RGB/zero values.
- frame_start coinciding with pix_valid: the pixel in that cycle already uses the newly latched frame/flip. Latching and address generation use the same combinational select.
- Palette write:
  - Entry updates at the Clk edge where pal_we=1.
  - A stage-2 lookup of the same index in that same cycle returns the old value; it takes effect from the next cycle.
  - Writes to TRANSP_CODE are stored but never displayed.
- Reset mid-stream: all in-flight pixels are discarded and out_valid drops asynchronously.

Decomposition:
- Package sprite_pkg holds:
  - typedef rgb_t, a packed struct {r, g, b} of 8 bits each;
  - localparam PAL_DEPTH = 2**CODE_W default;
  - default KEY_RGB;
  - the default frame-count constants per fighter.
- Sub-module sprite_palette_ram:
  - 2**CODE_W x 24 register file;
  - one synchronous write port;
  - one registered read port (old-data on collision);
  - async active-low reset to zero.
- The top level holds the latch, address stage and valid pipeline.

Test Plan:
- Reset then palette load: write pal[3]=24'h3952CE. Request (x=5,y=2), no flip, SPRITE_W=128, ROM model returns 3 → rom_addr=261 at N+1; out_valid at N+3 with RGB=39/52/CE, zero=0.
- Flip: frame_start with flip=1, request x=5,y=2 → rom_addr = 2*128+122 = 378.
- Transparency/OOB:
  - ROM returns 0 → zero=1, RGB=FF/FF/FF.
  - pix_x=128 → zero=1 and rom_addr=0, regardless of rom_code.
- Frame latching:
  - frame_sel changed 7→9 without frame_start → rom_frame stays 7.
  - Pulse frame_start → rom_frame 9.
  - frame_sel=40 latched → rom_frame 0.
- Palette collision: pal_we to index 3 with 24'h123456 in the same cycle stage 2 reads index 3 → that pixel shows the old 3952CE; the next pixel shows 12/34/56.
- Streaming/reset:
  - 20 back-to-back valid pixels → 20 consecutive out_valid cycles starting at N+3.
  - Assert Reset_n=0 mid-burst → out_valid=0 immediately and no stale pixel after release.
